// File: rtl/complex_dot_pkg.sv
// Shared types for the complex dot-product front end: complex values,
// product operand sets, issuer FSM states and the FP64 zero pattern.
package complex_dot_pkg;

    // Complex double {imag, real}; real sits in the low 64 bits.
    typedef struct packed {
        logic [63:0] im;
        logic [63:0] re;
    } cplx_t;

    // One complex product operand set; a1 sits in the low 64 bits.
    typedef struct packed {
        logic [63:0] b2;
        logic [63:0] a2;
        logic [63:0] b1;
        logic [63:0] a1;
    } cplx_operand_t;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } issuer_state_e;

    // +0.0 in IEEE-754 binary64; a padded product built from it contributes nothing.
    localparam logic [63:0] FP64_ZERO = 64'h0;

endpackage

// File: rtl/complex_result_slice.sv
// One-entry valid/ready output register carrying a complex value and its tag.
// The parent decides when to capture, so it can filter what gets stored.
module complex_result_slice
    import complex_dot_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             capture_i,
    input  cplx_t            data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             ready_o,
    output cplx_t            data_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             valid_o,
    input  logic             ready_i
);

    // Room for a new value when empty or when the held value drains this cycle.
    assign ready_o = !valid_o || ready_i;

    // Hold register: flush empties it, a capture replaces it, a drain clears valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            tag_o   <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (capture_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            tag_o   <= tag_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/complex_dot_issuer.sv
// Transmit-side front end of the complex dot-product unit. Packs SIZE
// operand beats into a vector, issues it over valid/ready while limiting
// vectors in flight to MAX_OUTSTANDING, and returns results tagged in order.
// Optional macro COMPLEX_DOT_ISSUER_LAST_EN adds elem_last_i, which closes a
// short vector early and pads the remaining slots with +0.0.
module complex_dot_issuer
    import complex_dot_pkg::*;
#(
    parameter int SIZE            = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [3:0][63:0]          elem_i,
    input  logic                      elem_valid_i,
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
    input  logic                      elem_last_i,
`endif
    output logic                      elem_ready_o,
    input  logic                      flush_i,
    output logic [SIZE*4-1:0][63:0]   dot_operands_o,
    output logic                      dot_valid_o,
    input  logic                      dot_ready_i,
    output logic                      dot_flush_o,
    input  logic [1:0][63:0]          dot_result_i,
    input  logic                      dot_res_valid_i,
    output logic                      dot_res_ready_o,
    output logic [1:0][63:0]          result_o,
    output logic [TAG_W-1:0]          result_tag_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      busy_o
);

    localparam int FILL_W = $clog2(SIZE);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(SIZE - 1);

    issuer_state_e               state_q, state_d;
    logic [FILL_W-1:0]           fill_cnt_q, fill_cnt_d;
    logic [OUT_W-1:0]            out_q, out_d;
    logic [TAG_W-1:0]            issue_tag_q, issue_tag_d;
    logic [TAG_W-1:0]            res_tag_q, res_tag_d;
    logic                        dot_valid_q, dot_valid_d;
    logic [SIZE*4-1:0][63:0]     buf_q, buf_d;
    logic                        dot_flush_q;

    logic          elem_hs, issue_hs, res_hs, last_beat, slice_ready;
    cplx_operand_t elem_s;
    cplx_t         dot_res_s, res_data;

    assign elem_s         = elem_i;
    assign dot_res_s      = dot_result_i;
    assign result_o       = res_data;
    assign elem_ready_o   = (state_q == FILL);
    assign dot_valid_o    = dot_valid_q;
    assign dot_operands_o = buf_q;
    assign dot_flush_o    = dot_flush_q;

    // With nothing in flight a stray result is swallowed rather than stalled.
    assign dot_res_ready_o = slice_ready || (out_q == '0);

    assign elem_hs  = elem_valid_i && elem_ready_o;
    assign issue_hs = dot_valid_q && dot_ready_i;
    assign res_hs   = dot_res_valid_i && slice_ready && (out_q != '0) && !flush_i;

`ifdef COMPLEX_DOT_ISSUER_LAST_EN
    assign last_beat = (fill_cnt_q == LAST_SLOT) || elem_last_i;
`else
    assign last_beat = (fill_cnt_q == LAST_SLOT);
`endif

    assign busy_o = (fill_cnt_q != '0) || (state_q == ISSUE) || (out_q != '0) || result_valid_o;

    // Next-state logic: fill/issue FSM, vector buffer, in-flight count and tags.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        out_d       = out_q;
        issue_tag_d = issue_tag_q;
        res_tag_d   = res_tag_q;
        buf_d       = buf_q;
        dot_valid_d = 1'b0;
        if (flush_i) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            out_d      = '0;
        end else begin
            if (elem_hs) begin
                for (int k = 0; k < SIZE; k++) begin
                    if (FILL_W'(k) == fill_cnt_q) begin
                        buf_d[4*k +: 4] = elem_s;
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
                    end else if (elem_last_i && (FILL_W'(k) > fill_cnt_q)) begin
                        buf_d[4*k +: 4] = {FP64_ZERO, FP64_ZERO, FP64_ZERO, FP64_ZERO};
`endif
                    end
                end
                if (last_beat) begin
                    state_d    = ISSUE;
                    fill_cnt_d = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            if (issue_hs) begin
                state_d     = FILL;
                issue_tag_d = issue_tag_q + 1'b1;
            end
            if (res_hs) begin
                res_tag_d = res_tag_q + 1'b1;
            end
            case ({issue_hs, res_hs})
                2'b10:   out_d = out_q + 1'b1;
                2'b01:   out_d = out_q - 1'b1;
                default: out_d = out_q;
            endcase
            // Registered issue request; once up it can only fall on the handshake,
            // because the in-flight count never grows while a vector waits.
            dot_valid_d = (state_d == ISSUE) && (out_d < MAX_OUT);
        end
    end

    // State register for the FSM, buffer, counters and the forwarded flush pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            out_q       <= '0;
            issue_tag_q <= '0;
            res_tag_q   <= '0;
            dot_valid_q <= 1'b0;
            buf_q       <= '0;
            dot_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            out_q       <= out_d;
            issue_tag_q <= issue_tag_d;
            res_tag_q   <= res_tag_d;
            dot_valid_q <= dot_valid_d;
            buf_q       <= buf_d;
            dot_flush_q <= flush_i;
        end
    end

    complex_result_slice #(
        .TAG_W (TAG_W)
    ) u_result_slice (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .capture_i (res_hs),
        .data_i    (dot_res_s),
        .tag_i     (res_tag_q),
        .ready_o   (slice_ready),
        .data_o    (res_data),
        .tag_o     (result_tag_o),
        .valid_o   (result_valid_o),
        .ready_i   (result_ready_i)
    );

endmodule

// File: tb/tb_complex_dot_issuer.sv
// Randomized bench for complex_dot_issuer against a transaction-level model
// of the beat/vector/result rules. Honours COMPLEX_DOT_ISSUER_LAST_EN.
module tb_complex_dot_issuer;

    localparam int SIZE  = 16;
    localparam int MAXO  = 4;
    localparam int TAG_W = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0][63:0]        elem_i;
    logic                    elem_valid_i;
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
    logic                    elem_last_i;
`endif
    logic                    elem_ready_o;
    logic                    flush_i;
    logic [SIZE*4-1:0][63:0] dot_operands_o;
    logic                    dot_valid_o;
    logic                    dot_ready_i;
    logic                    dot_flush_o;
    logic [1:0][63:0]        dot_result_i;
    logic                    dot_res_valid_i;
    logic                    dot_res_ready_o;
    logic [1:0][63:0]        result_o;
    logic [TAG_W-1:0]        result_tag_o;
    logic                    result_valid_o;
    logic                    result_ready_i;
    logic                    busy_o;

    complex_dot_issuer #(
        .SIZE(SIZE), .MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .elem_i(elem_i), .elem_valid_i(elem_valid_i),
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
        .elem_last_i(elem_last_i),
`endif
        .elem_ready_o(elem_ready_o), .flush_i(flush_i),
        .dot_operands_o(dot_operands_o), .dot_valid_o(dot_valid_o),
        .dot_ready_i(dot_ready_i), .dot_flush_o(dot_flush_o),
        .dot_result_i(dot_result_i), .dot_res_valid_i(dot_res_valid_i),
        .dot_res_ready_o(dot_res_ready_o),
        .result_o(result_o), .result_tag_o(result_tag_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model state: beats gathered, whether a full vector awaits issue, vectors
    // in flight, the output register and the next result sequence number.
    logic [63:0] m_vec [SIZE*4];
    int          m_fill;
    bit          m_pend;
    bit          m_dv;
    int          m_out;
    int          m_rtag;
    bit          m_rv;
    logic [127:0] m_rdat;
    int          m_rtag_o;
    bit          m_dfl;

    int ev_pct, dr_pct, rv_pct, rr_pct, fl_pml;

    task automatic model_reset();
        m_fill = 0; m_pend = 0; m_dv = 0; m_out = 0; m_rtag = 0;
        m_rv = 0; m_rdat = '0; m_rtag_o = 0; m_dfl = 0;
        for (int i = 0; i < SIZE*4; i++) m_vec[i] = '0;
    endtask

    // Apply the rules for one clock edge given the inputs currently driven.
    task automatic model_step();
        bit iss, racc, eacc, last, rr;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush_i) begin
            m_fill = 0; m_pend = 0; m_dv = 0; m_out = 0; m_rv = 0; m_dfl = 1;
            return;
        end
        m_dfl = 0;
        rr   = (m_out == 0) || !m_rv || result_ready_i;
        iss  = m_dv && dot_ready_i;
        racc = dot_res_valid_i && rr && (m_out > 0);
        eacc = !m_pend && elem_valid_i;
        if (iss)  m_out++;
        if (racc) m_out--;
        if (iss)  m_pend = 0;
        if (eacc) begin
            for (int j = 0; j < 4; j++) m_vec[m_fill*4 + j] = elem_i[j];
            last = (m_fill == SIZE-1);
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
            if (elem_last_i) begin
                last = 1;
                for (int s = (m_fill+1)*4; s < SIZE*4; s++) m_vec[s] = 64'h0;
            end
`endif
            if (last) begin
                m_pend = 1;
                m_fill = 0;
            end else begin
                m_fill++;
            end
        end
        if (racc) begin
            m_rv = 1; m_rdat = dot_result_i; m_rtag_o = m_rtag;
            m_rtag = (m_rtag + 1) % (1 << TAG_W);
        end else if (result_ready_i) begin
            m_rv = 0;
        end
        m_dv = m_pend && (m_out < MAXO);
    endtask

    task automatic check_outputs();
        check("elem_ready", elem_ready_o, !m_pend);
        check("dot_valid", dot_valid_o, m_dv);
        if (m_dv)
            for (int k = 0; k < SIZE*4; k++) check($sformatf("operand%0d", k), dot_operands_o[k], m_vec[k]);
        check("dot_res_ready", dot_res_ready_o, (m_out == 0) || !m_rv || result_ready_i);
        check("result_valid", result_valid_o, m_rv);
        if (m_rv) begin
            check("result", result_o, m_rdat);
            check("result_tag", result_tag_o, m_rtag_o);
        end
        check("dot_flush", dot_flush_o, m_dfl);
        check("busy", busy_o, (m_fill != 0) || m_pend || (m_out != 0) || m_rv);
    endtask

    task automatic drive_random();
        rst             = 1'b0;
        elem_valid_i    = ($urandom_range(0, 99) < ev_pct);
        for (int j = 0; j < 4; j++) elem_i[j] = {$urandom(), $urandom()};
        dot_ready_i     = ($urandom_range(0, 99) < dr_pct);
        dot_res_valid_i = ($urandom_range(0, 99) < rv_pct);
        dot_result_i[0] = {$urandom(), $urandom()};
        dot_result_i[1] = {$urandom(), $urandom()};
        result_ready_i  = ($urandom_range(0, 99) < rr_pct);
        flush_i         = ($urandom_range(0, 999) < fl_pml);
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
        elem_last_i     = ($urandom_range(0, 99) < 15);
`endif
    endtask

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_outputs();
            model_step();
        end
    endtask

    initial begin
        rst = 1'b1; elem_i = '0; elem_valid_i = 1'b0; flush_i = 1'b0;
        dot_ready_i = 1'b0; dot_result_i = '0; dot_res_valid_i = 1'b0;
        result_ready_i = 1'b0;
`ifdef COMPLEX_DOT_ISSUER_LAST_EN
        elem_last_i = 1'b0;
`endif
        model_reset();

        // Reset state, including cleared data registers.
        @(negedge clk);
        #1;
        check("rst_result", result_o, '0);
        check("rst_result_tag", result_tag_o, '0);
        for (int k = 0; k < SIZE*4; k++) check("rst_operand", dot_operands_o[k], '0);
        check_outputs();
        model_step();

        // Directed first vector: beat k carries a1=k, unit always ready, no results.
        for (int k = 0; k < SIZE + 4; k++) begin
            @(negedge clk);
            rst = 1'b0;
            elem_i = '0;
            elem_i[0] = 64'(k);
            elem_valid_i = (k < SIZE);
            dot_ready_i = 1'b1;
            #1;
            check_outputs();
            model_step();
        end

        // General traffic with occasional flushes.
        ev_pct = 70; dr_pct = 60; rv_pct = 40; rr_pct = 60; fl_pml = 10;
        run_random(1500);
        // Results scarce: in-flight limit throttles issue.
        ev_pct = 90; dr_pct = 100; rv_pct = 5; rr_pct = 100; fl_pml = 0;
        run_random(600);
        // Results plentiful, downstream slow: output register stalls the unit.
        ev_pct = 90; dr_pct = 80; rv_pct = 70; rr_pct = 20; fl_pml = 3;
        run_random(800);
        // Reset in the middle of traffic, then resume.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive_random();
            rst = 1'b1;
            #1;
            check_outputs();
            model_step();
        end
        ev_pct = 80; dr_pct = 70; rv_pct = 50; rr_pct = 70; fl_pml = 5;
        run_random(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_dot_issuer.md
Name: complex_dot_issuer

Overview:
- Transmit-side front end for the complex dot-product unit. Takes one complex product operand set per beat, {b2,a2,b1,a1}, as 64-bit doubles (operand 1 = a1 + i·b1, operand 2 = a2 + i·b2).
- Packs SIZE beats into one vector and issues it to the dot-product unit over valid/ready.
- Accepts the unit's {imag,real} results, tags them with an in-order sequence number and forwards them downstream.
- Tracks ops in flight and throttles issue at MAX_OUTSTANDING.

Parameters:
- SIZE, 16, complex products per dot product; power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum issued-but-unreturned vectors; ≥1.
- TAG_W, 4, sequence-tag width; tags wrap modulo 2^TAG_W.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- elem_i  in  [3:0][63:0]  one product operand set {b2,a2,b1,a1}.
- elem_valid_i  in  1  element valid.
- elem_ready_o  out  1  element ready.
- flush_i  in  1  synchronous abort.
- dot_operands_o  out  [SIZE*4-1:0][63:0]  packed vector; beat k occupies indices 4k..4k+3.
- dot_valid_o  out  1  vector valid.
- dot_ready_i  in  1  dot unit ready.
- dot_flush_o  out  1  flush forwarded to dot unit.
- dot_result_i  in  [1:0][63:0]  dot unit result {imag,real}.
- dot_res_valid_i  in  1  result valid.
- dot_res_ready_o  out  1  result ready.
- result_o  out  [1:0][63:0]  registered result.
- result_tag_o  out  TAG_W  sequence tag of result_o.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  downstream ready.
- busy_o  out  1  any data held or in flight.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous, active-high.
- Reset values: state=FILL, fill count=0, outstanding=0, issue tag=0, result tag=0. All valids 0, dot_flush_o=0, busy_o=0. Vector buffer and result_o are 0.
- FILL state:
  - elem_ready_o=1.
  - On elem_valid_i&elem_ready_o, elem_i is written to buffer slot fill_cnt and fill_cnt increments.
  - The beat accepted with fill_cnt==SIZE-1 moves the FSM to ISSUE and resets fill_cnt to 0.
- ISSUE state:
  - elem_ready_o=0.
  - dot_valid_o = (outstanding < MAX_OUTSTANDING). It is registered and asserts the cycle after the SIZE-th beat when not throttled.
  - dot_operands_o is stable while dot_valid_o=1.
  - On dot_valid_o&dot_ready_i: outstanding+1, issue tag+1, next state FILL.
  - Once raised, dot_valid_o is not dropped before the handshake.
- Minimum throughput: one vector per SIZE+1 cycles.
- Result path:
  - One-entry output register. dot_res_ready_o = !result_valid_o | result_ready_i (pass-through when draining).
  - On dot_res handshake: result_o ← dot_result_i, result_tag_o ← result tag, result tag+1, outstanding−1. result_valid_o is set the next cycle.
  - result_valid_o clears on result_ready_i with no new capture.
- Simultaneous issue and result handshake in one cycle: outstanding unchanged.
- Protocol errors: a result with outstanding==0 is a protocol violation. It is dropped (dot_res_ready_o=1, no capture) and the counter does not underflow.
- Tag wrap: 2^TAG_W−1 → 0 for both counters.
- flush_i (priority below rst_i, above everything else):
  - Next cycle: FILL, fill_cnt=0, outstanding=0, result_valid_o=0, dot_valid_o=0.
  - Tags are preserved.
  - dot_flush_o = flush_i, registered, 1 cycle.
  - A handshake coincident with flush_i is discarded.
- Reset or flush mid-fill: partial vector abandoned; buffer contents don't care.
- busy_o = (fill_cnt≠0) | (state==ISSUE) | (outstanding≠0) | result_valid_o.

Optional Feature:
- Macro: COMPLEX_DOT_ISSUER_LAST_EN.
- Defined:
  - Adds input elem_last_i (1 bit), sampled with elem handshake.
  - Last beat at fill_cnt=m<SIZE-1 goes to ISSUE with slots m+1..SIZE-1 forced to +0.0 (64'h0), so the products contribute zero.
  - elem_last_i at slot SIZE-1 is ignored.
- Undefined: port absent; vectors are always exactly SIZE beats.

Decomposition:
- Shared package complex_dot_pkg:
  - cplx_t packed struct {logic [63:0] im, re}.
  - cplx_operand_t {b2,a2,b1,a1}.
  - typedef enum {FILL, ISSUE} issuer_state_e.
  - FP64_ZERO constant.
- One natural sub-module: complex_result_slice, the one-entry valid/ready output register with tag. Also reusable on other dot-unit outputs.

Test Plan:
- Reset, then 16 beats where beat k has a1=k, others 0, with dot_ready_i=1 → dot_valid_o high exactly one cycle after beat 16; dot_operands_o[4k]=k; outstanding=1; busy_o=1.
- Hold dot_ready_i=0 for 5 cycles during ISSUE → dot_valid_o stays 1, operands unchanged, elem_ready_o=0; the handshake on cycle 6 returns the FSM to FILL.
- Issue 4 vectors without results (MAX_OUTSTANDING=4) → the 5th vector's dot_valid_o stays 0. Return one result → dot_valid_o rises the next cycle.
- Return results 0xA/0xB back-to-back with result_ready_i=0 then 1 → second result stalled by dot_res_ready_o=0; outputs tags 0 then 1 in order. Issue 17 vectors total → tag wraps 15→0.
- flush_i after 7 beats with 2 outstanding → next cycle fill_cnt=0, outstanding=0, dot_flush_o=1 for one cycle; busy_o=0 the following cycle.
- With COMPLEX_DOT_ISSUER_LAST_EN, elem_last_i on beat 3 → issue with slots 3..15 (indices 12..63) all 64'h0 and slots 0..2 preserved.
